// File: rtl/mem_stage_pkg.sv
// Shared widths, FSM state encoding and the latched memory-request record
// used by the memory-access pipeline stage.
package mem_stage_pkg;

  localparam int DATA_W = 128;
  localparam int PC_W   = 15;
  localparam int ADDR_W = 15;
  localparam int DEST_W = 4;
  localparam int WDOG_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  // Everything needed to drive the memory port and finish writeback once
  // the execute stage has moved on.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DEST_W-1:0] dest;
    logic              we;
    logic              is_load;
  } mem_req_t;

endpackage

// File: rtl/mem_watchdog.sv
// Access watchdog: counts cycles spent waiting for dmem_ack and raises a
// one-cycle expiry plus a sticky error flag (used only with MEM_TIMEOUT_EN).
module mem_watchdog
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic ack_i,
  output logic expired_o,
  output logic err_o
);

  logic [WDOG_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;

  // Expiry fires on the TIMEOUT_CYC-th unanswered cycle; an ack in that
  // same cycle still wins.
  assign expired_o = active_i && !ack_i && (cnt_q == WDOG_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = '0;
    if (active_i && !ack_i && !expired_o) cnt_d = cnt_q + 1'b1;
    err_d = err_q | expired_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: branch resolution, 128-bit load/store over a
// req/ack port, registered writeback. Optional watchdog under MEM_TIMEOUT_EN.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] store_data,
  input  logic              zero_flag,
  input  logic [PC_W-1:0]   branch_target,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              branch_en,
  input  logic              reg_we_in,
  input  logic [DEST_W-1:0] dest_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              pc_src,
  output logic [PC_W-1:0]   pc_target,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we,
  output logic [DEST_W-1:0] wb_dest,
  output logic              mem_err
);

  state_e            state_q, state_d;
  mem_req_t          req_q, req_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q;
  logic              wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [DEST_W-1:0] wb_dest_q, wb_dest_d;
  logic              pc_src_q, pc_src_d;
  logic [PC_W-1:0]   pc_target_q, pc_target_d;
  logic              timeout;
  logic              unused_alu_hi;

  assign unused_alu_hi = ^alu_in[DATA_W-1:ADDR_W];

`ifdef MEM_TIMEOUT_EN
  mem_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .active_i (state_q == ACCESS),
    .ack_i    (dmem_ack),
    .expired_o(timeout),
    .err_o    (mem_err)
  );
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  // ready_q keeps in_ready low until the first clock after reset release.
  assign in_ready   = ready_q && (state_q == IDLE);
  assign dmem_req   = (state_q == ACCESS);
  assign dmem_we    = dmem_req && !req_q.is_load;
  assign dmem_addr  = req_q.addr;
  assign dmem_wdata = req_q.wdata;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rdata_d     = rdata_q;
    wb_valid_d  = 1'b0;
    wb_data_d   = wb_data_q;
    wb_we_d     = wb_we_q;
    wb_dest_d   = wb_dest_q;
    pc_src_d    = 1'b0;
    pc_target_d = pc_target_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (mem_read || mem_write) begin
            // Read+write together is a store with no register write.
            req_d.addr    = alu_in[ADDR_W-1:0];
            req_d.wdata   = store_data;
            req_d.dest    = dest_in;
            req_d.we      = reg_we_in && !mem_write;
            req_d.is_load = !mem_write;
            state_d       = ACCESS;
          end else begin
            wb_valid_d = 1'b1;
            wb_data_d  = alu_in;
            wb_we_d    = reg_we_in && !branch_en;
            wb_dest_d  = dest_in;
            if (branch_en && zero_flag) begin
              pc_src_d    = 1'b1;
              pc_target_d = branch_target;
            end
          end
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          rdata_d = dmem_rdata;
          state_d = DONE;
        end else if (timeout) begin
          rdata_d  = '0;
          req_d.we = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        wb_valid_d = 1'b1;
        wb_data_d  = req_q.is_load ? rdata_q : '0;
        wb_we_d    = req_q.is_load && req_q.we;
        wb_dest_d  = req_q.dest;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      req_q       <= '0;
      rdata_q     <= '0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_we_q     <= 1'b0;
      wb_dest_q   <= '0;
      pc_src_q    <= 1'b0;
      pc_target_q <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= 1'b1;
      req_q       <= req_d;
      rdata_q     <= rdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_we_q     <= wb_we_d;
      wb_dest_q   <= wb_dest_d;
      pc_src_q    <= pc_src_d;
      pc_target_q <= pc_target_d;
    end
  end

  assign wb_valid  = wb_valid_q;
  assign wb_data   = wb_data_q;
  assign wb_we     = wb_we_q;
  assign wb_dest   = wb_dest_q;
  assign pc_src    = pc_src_q;
  assign pc_target = pc_target_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases then random ops against a
// transaction-level model; define MEM_TIMEOUT_EN to exercise the watchdog.
module tb_mem_access_stage;
  import mem_stage_pkg::*;

`ifdef MEM_TIMEOUT_EN
  localparam int TO_CYC = 4;
  localparam int MAXW   = 2;
`else
  localparam int TO_CYC = 255;
  localparam int MAXW   = 6;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] alu_in, store_data;
  logic              zero_flag;
  logic [PC_W-1:0]   branch_target;
  logic              mem_read, mem_write, branch_en, reg_we_in;
  logic [DEST_W-1:0] dest_in;
  logic              dmem_req, dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;
  logic              pc_src;
  logic [PC_W-1:0]   pc_target;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic              wb_we;
  logic [DEST_W-1:0] wb_dest;
  logic              mem_err;

  int checks = 0;
  int errors = 0;
  logic exp_err = 1'b0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_in(alu_in), .store_data(store_data), .zero_flag(zero_flag),
    .branch_target(branch_target), .mem_read(mem_read), .mem_write(mem_write),
    .branch_en(branch_en), .reg_we_in(reg_we_in), .dest_in(dest_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc_src(pc_src), .pc_target(pc_target), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_we(wb_we), .wb_dest(wb_dest), .mem_err(mem_err)
  );

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("ready_wait", in_ready, 1);
  endtask

  // Non-memory op: ALU pass-through or branch. Expected results follow
  // directly from the op fields.
  task automatic do_alu(input logic [DATA_W-1:0] a, input logic we, input logic [DEST_W-1:0] d,
                        input logic br, input logic z, input logic [PC_W-1:0] tgt);
    logic taken;
    wait_ready();
    in_valid = 1'b1; alu_in = a; reg_we_in = we; dest_in = d;
    branch_en = br; zero_flag = z; branch_target = tgt;
    mem_read = 1'b0; mem_write = 1'b0; store_data = rand128();
    dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = rand128();
    tick();
    in_valid = 1'b0; dmem_ack = 1'b0;
    taken = br && z;
    check("alu_wb_valid", wb_valid, 1);
    check("alu_wb_data", wb_data, a);
    check("alu_wb_we", wb_we, we && !br);
    check("alu_wb_dest", wb_dest, d);
    check("alu_pc_src", pc_src, taken);
    if (taken) check("alu_pc_target", pc_target, tgt);
    check("alu_in_ready", in_ready, 1);
    check("alu_no_req", dmem_req, 0);
    tick();
    check("alu_wb_pulse_end", wb_valid, 0);
    check("alu_pc_src_end", pc_src, 0);
  endtask

  // Memory op answered after waitn extra cycles of dmem_req.
  task automatic do_mem(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rdd,
                        input int waitn, input logic we, input logic [DEST_W-1:0] d);
    logic [DATA_W-1:0] a;
    logic is_load;
    is_load = rd && !wr;
    a = rand128();
    a[ADDR_W-1:0] = addr;
    wait_ready();
    in_valid = 1'b1; alu_in = a; store_data = wd; mem_read = rd; mem_write = wr;
    reg_we_in = we; dest_in = d; branch_en = 1'b0; zero_flag = 1'($urandom_range(0, 1));
    tick();
    for (int i = 0; i <= waitn; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      mem_read = 1'b0; mem_write = 1'b0; branch_en = 1'b1; zero_flag = 1'b1;
      alu_in = rand128(); store_data = rand128();
      check("acc_req", dmem_req, 1);
      check("acc_we", dmem_we, wr);
      check("acc_addr", dmem_addr, addr);
      if (wr) check("acc_wdata", dmem_wdata, wd);
      check("acc_in_ready", in_ready, 0);
      check("acc_no_wb", wb_valid, 0);
      check("acc_no_pc_src", pc_src, 0);
      if (i == waitn) begin
        dmem_ack = 1'b1;
        dmem_rdata = rdd;
      end
      tick();
      dmem_ack = 1'b0;
      dmem_rdata = rand128();
    end
    in_valid = 1'b0; branch_en = 1'b0;
    check("done_req_low", dmem_req, 0);
    check("done_in_ready", in_ready, 0);
    check("done_no_wb_yet", wb_valid, 0);
    tick();
    check("mem_wb_valid", wb_valid, 1);
    check("mem_wb_we", wb_we, is_load && we);
    check("mem_wb_dest", wb_dest, d);
    if (is_load) check("mem_wb_data", wb_data, rdd);
    check("mem_in_ready", in_ready, 1);
    check("mem_err_state", mem_err, exp_err);
    tick();
    check("mem_wb_pulse_end", wb_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; alu_in = '0; store_data = '0; zero_flag = 1'b0;
    branch_target = '0; mem_read = 1'b0; mem_write = 1'b0; branch_en = 1'b0;
    reg_we_in = 1'b0; dest_in = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_dmem_addr", dmem_addr, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_pc_src", pc_src, 0);
    check("rst_mem_err", mem_err, 0);
    tick();
    tick();
    rst = 1'b0;
    check("rel_in_ready_low", in_ready, 0);
    tick();
    check("rel_in_ready_high", in_ready, 1);

    // Directed cases
    do_alu(128'h5, 1'b1, 4'd3, 1'b0, 1'b0, 15'h0);
    do_mem(1'b1, 1'b0, 15'h0010, rand128(), 128'hDEADBEEF, 2, 1'b1, 4'd7);
    do_mem(1'b0, 1'b1, 15'h7FFF, 128'hA5, rand128(), 1, 1'b1, 4'd2);
    do_alu(rand128(), 1'b1, 4'd9, 1'b1, 1'b1, 15'h0100);
    do_alu(rand128(), 1'b1, 4'd9, 1'b1, 1'b0, 15'h0100);
    do_mem(1'b1, 1'b1, 15'h1234, 128'h77, rand128(), 0, 1'b1, 4'd5);
    do_mem(1'b1, 1'b0, 15'h0000, rand128(), rand128(), 0, 1'b1, 4'd15);

    // Reset in the middle of an access: request drops without a clock.
    wait_ready();
    in_valid = 1'b1; alu_in = 128'h55; mem_read = 1'b1; mem_write = 1'b0;
    reg_we_in = 1'b1; dest_in = 4'd1;
    tick();
    in_valid = 1'b0; mem_read = 1'b0;
    check("mid_req_high", dmem_req, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_req", dmem_req, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_addr", dmem_addr, 0);
    tick();
    dmem_ack = 1'b1;
    check("mid_rst_no_wb", wb_valid, 0);
    rst = 1'b0;
    exp_err = 1'b0;
    tick();
    dmem_ack = 1'b0;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_no_wb", wb_valid, 0);
    check("post_rst_no_req", dmem_req, 0);
    do_mem(1'b1, 1'b0, 15'h0ABC, rand128(), 128'hCAFE, 1, 1'b1, 4'd4);

    // Random mix
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 4))
        0: do_alu(rand128(), 1'($urandom_range(0, 1)), 4'($urandom), 1'b0, 1'($urandom_range(0, 1)), 15'($urandom));
        1: do_alu(rand128(), 1'($urandom_range(0, 1)), 4'($urandom), 1'b1, 1'($urandom_range(0, 1)), 15'($urandom));
        2: do_mem(1'b1, 1'b0, 15'($urandom), rand128(), rand128(), $urandom_range(0, MAXW), 1'($urandom_range(0, 1)), 4'($urandom));
        3: do_mem(1'b0, 1'b1, 15'($urandom), rand128(), rand128(), $urandom_range(0, MAXW), 1'($urandom_range(0, 1)), 4'($urandom));
        default: do_mem(1'b1, 1'b1, 15'($urandom), rand128(), rand128(), $urandom_range(0, MAXW), 1'b1, 4'($urandom));
      endcase
    end

`ifdef MEM_TIMEOUT_EN
    // Unanswered load: four request cycles, then a dead writeback and a sticky error.
    wait_ready();
    in_valid = 1'b1; alu_in = 128'h0321; mem_read = 1'b1; mem_write = 1'b0;
    reg_we_in = 1'b1; dest_in = 4'd6;
    tick();
    in_valid = 1'b0; mem_read = 1'b0;
    for (int i = 0; i < TO_CYC; i++) begin
      check("to_req", dmem_req, 1);
      tick();
    end
    check("to_req_drop", dmem_req, 0);
    dmem_ack = 1'b1;
    dmem_rdata = 128'hBAD;
    tick();
    dmem_ack = 1'b0;
    exp_err = 1'b1;
    check("to_wb_valid", wb_valid, 1);
    check("to_wb_we", wb_we, 0);
    check("to_wb_data", wb_data, 0);
    check("to_mem_err", mem_err, 1);
    tick();
    do_alu(rand128(), 1'b1, 4'd8, 1'b0, 1'b0, 15'h0);
    check("to_err_sticky", mem_err, 1);
    rst = 1'b1;
    #1;
    check("to_err_clear", mem_err, 0);
    tick();
    rst = 1'b0;
    exp_err = 1'b0;
    tick();
`endif

    check("final_mem_err", mem_err, exp_err);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of the execute stage. Consumes the 128-bit ALU result, the store operand, the zero flag and the 15-bit branch target.
- Resolves branches (pc_src/pc_target back to fetch) and runs 128-bit loads and stores against data memory over a req/ack handshake.
- Stalls upstream while an access is outstanding. Delivers a registered result to writeback.

Parameters:
- DATA_W, 128, datapath/vector width
- PC_W, 15, program counter and branch target width
- ADDR_W, 15, data memory address width; taken from alu_in[ADDR_W-1:0]
- DEST_W, 4, destination register index width
- TIMEOUT_CYC, 255, watchdog limit in cycles (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  execute result valid this cycle
- in_ready  out  1  stage can accept; low = upstream stall
- alu_in  in  DATA_W  ALU result (memory address or writeback value)
- store_data  in  DATA_W  store operand
- zero_flag  in  1  ALU zero flag
- branch_target  in  PC_W  computed branch target
- mem_read  in  1  load op
- mem_write  in  1  store op
- branch_en  in  1  conditional branch op (taken when zero_flag=1)
- reg_we_in  in  1  writeback enable
- dest_in  in  DEST_W  destination register
- dmem_req  out  1  memory request
- dmem_we  out  1  1=store, 0=load
- dmem_addr  out  ADDR_W  request address
- dmem_wdata  out  DATA_W  store data
- dmem_ack  in  1  memory completion (1-cycle pulse)
- dmem_rdata  in  DATA_W  load data, valid with dmem_ack
- pc_src  out  1  branch taken pulse
- pc_target  out  PC_W  redirect PC, valid with pc_src
- wb_valid  out  1  writeback result valid (1-cycle pulse)
- wb_data  out  DATA_W  load data or ALU result
- wb_we  out  1  register write enable
- wb_dest  out  DEST_W  destination register
- mem_err  out  1  sticky timeout error (MEM_TIMEOUT_EN only; otherwise tied 0)

Behaviour:
- Reset (async, rst=1): all outputs 0, FSM to IDLE, in_ready=0 while rst high, in_ready=1 from the first clk after release.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, in_ready=1. On in_valid:
  - Non-memory op: wb_* registered next edge, wb_valid=1 one cycle. Latency 1. Stay in IDLE.
  - mem_read or mem_write: latch address (alu_in[ADDR_W-1:0]), store data, dest and reg_we; go to ACCESS.
  - mem_read and mem_write both high: treated as store; reg write suppressed.
- ACCESS, in_ready=0:
  - dmem_req=1; dmem_we/addr/wdata held stable until ack.
  - On dmem_ack: capture dmem_rdata (load), drop dmem_req the next cycle, go to DONE.
  - Ack in the same cycle req first rises is legal.
- DONE, in_ready=0: wb_valid=1 for one cycle. Load: wb_data=rdata, wb_we=latched reg_we. Store: wb_we=0. Return to IDLE.
- Load-to-writeback latency is 2 + memory wait cycles after acceptance.
- Branch: accepted with branch_en=1 and zero_flag=1 → pc_src=1, pc_target=branch_target for exactly one cycle after acceptance. branch_en=1 with zero_flag=0 → no pulse. Branches never write back (wb_we=0, wb_valid=1).
- dmem_ack outside ACCESS is ignored.
- in_valid while in_ready=0 is not accepted. Upstream must hold its data.
- Reset mid-ACCESS aborts immediately: dmem_req drops asynchronously, no writeback issued.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: 8-bit watchdog counter runs in ACCESS. Reaching TIMEOUT_CYC without ack forces DONE with wb_we=0, wb_data=0, sets sticky mem_err (cleared only by rst). A late ack is ignored.
- Undefined: no counter; ACCESS waits indefinitely; mem_err tied 0.

Decomposition:
- Package mem_stage_pkg: DATA_W/PC_W/ADDR_W/DEST_W constants, state enum {IDLE, ACCESS, DONE}, packed struct for the latched request (addr, wdata, dest, we, is_load).
- Sub-module: mem_watchdog (counter + sticky error), instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- ALU pass-through: in_valid, alu_in=128'h5, reg_we_in=1, dest=3 → next cycle wb_valid=1, wb_data=5, wb_dest=3, in_ready stays 1.
- Load with 3-cycle wait: alu_in=0x0010, ack on 3rd req cycle with rdata=128'hDEADBEEF → dmem_addr=0x0010, in_ready=0 for 4 cycles, wb_data=DEADBEEF one cycle after ack.
- Store: store_data=128'hA5, alu_in=0x7FFF → dmem_we=1, dmem_addr=0x7FFF, dmem_wdata=A5; writeback has wb_we=0.
- Branch taken/not taken: branch_target=0x0100, zero_flag=1 → pc_src pulse with pc_target=0x0100; zero_flag=0 → no pc_src.
- Reset mid-access: assert rst during ACCESS → dmem_req=0 immediately, no wb_valid; next op after release behaves normally.
- MEM_TIMEOUT_EN, TIMEOUT_CYC=4, no ack → after 4 cycles wb_valid=1 with wb_we=0, mem_err=1 and it stays 1 until rst.
